// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcodes and
// register-file geometry.
package alu_sequencer_pkg;

  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  localparam logic [1:0] OP_SUM  = 2'b00;
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

endpackage

// File: rtl/alu_regfile.sv
// Four-entry register file with one synchronous write port and three
// combinational read ports (two operand sources plus a debug tap).
module alu_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [WIDTH:0]       wdata_i,
  input  logic [REG_IDX_W-1:0] raddr1_i,
  input  logic [REG_IDX_W-1:0] raddr2_i,
  input  logic [REG_IDX_W-1:0] dbg_addr_i,
  output logic [WIDTH:0]       rdata1_o,
  output logic [WIDTH:0]       rdata2_o,
  output logic [WIDTH:0]       dbg_data_o
);

  logic [WIDTH:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = mem_q[raddr1_i];
  assign rdata2_o   = mem_q[raddr2_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state sequencer that fetches operands from a small register file,
// drives an external ALU and writes the result back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [1:0]           instr_op,
  input  logic                 instr_ci,
  input  logic [REG_IDX_W-1:0] instr_rs1,
  input  logic [REG_IDX_W-1:0] instr_rs2,
  input  logic [REG_IDX_W-1:0] instr_rd,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_addr,
  input  logic [WIDTH:0]       ld_data,
  output logic [WIDTH:0]       alu_a,
  output logic [WIDTH:0]       alu_b,
  output logic [1:0]           alu_op,
  output logic                 alu_ci,
  input  logic [WIDTH:0]       alu_out,
  input  logic                 alu_cero,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [WIDTH:0]       dbg_data,
  output logic                 zero_flag,
  output logic                 done,
  output logic                 div_zero
);

  state_e               state_q, state_d;
  logic [REG_IDX_W-1:0] rs1_q, rs2_q, rd_q;
  logic [1:0]           op_q;
  logic                 ci_q;
  logic [WIDTH:0]       alu_a_q, alu_b_q;
  logic [1:0]           alu_op_q;
  logic                 alu_ci_q;
  logic                 zero_q, done_q, div_zero_q;

  logic                 accept;
  logic                 div_by_zero;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [WIDTH:0]       rf_wdata;
  logic [WIDTH:0]       rf_rdata1, rf_rdata2;

  alu_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr1_i   (rs1_q),
    .raddr2_i   (rs2_q),
    .dbg_addr_i (dbg_addr),
    .rdata1_o   (rf_rdata1),
    .rdata2_o   (rf_rdata2),
    .dbg_data_o (dbg_data)
  );

  // The divide check looks at the registered operands that the ALU sees in WB.
  assign div_by_zero = (alu_op_q == OP_DIV) && (alu_b_q == '0);

  always_comb begin
    state_d     = state_q;
    instr_ready = (state_q == IDLE) && !ld_valid;
    accept      = instr_valid && instr_ready;
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          rf_we = 1'b1;
        end else if (accept) begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WB;
      WB: begin
        state_d = IDLE;
        if (!div_by_zero) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = alu_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      op_q       <= '0;
      ci_q       <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      alu_ci_q   <= 1'b0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == WB);
      div_zero_q <= (state_q == WB) && div_by_zero;
      if (accept) begin
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        rd_q  <= instr_rd;
        op_q  <= instr_op;
        ci_q  <= instr_ci;
      end
      if (state_q == ISSUE) begin
        alu_a_q  <= rf_rdata1;
        alu_b_q  <= rf_rdata2;
        alu_op_q <= op_q;
        alu_ci_q <= ci_q;
      end
      if ((state_q == WB) && !div_by_zero) begin
        zero_q <= alu_cero;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_ci    = alu_ci_q;
  assign zero_flag = zero_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;

endmodule
